// File: rtl/freq_meter_if.sv
// Measurement control inputs and result outputs exchanged between freq_meter and its user.
interface freq_meter_if #(
    parameter int CNT_W = 26,
    parameter int PER_W = 26
);
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_cnt;
    logic [PER_W-1:0] period;
    logic [PER_W-1:0] high_time;
    logic             valid;
    logic             overflow;
    logic             no_signal;

    modport master (
        output en, sig_in,
        input  freq_cnt, period, high_time, valid, overflow, no_signal
    );

    modport slave (
        input  en, sig_in,
        output freq_cnt, period, high_time, valid, overflow, no_signal
    );
endinterface

// File: rtl/freq_meter.sv
// Frequency, period and high-time meter for a slow square wave sampled in the clk domain.
// A gate FSM counts edges per fixed window; a period FSM times consecutive rises.
module freq_meter #(
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 26,
    parameter int PER_W       = 26
) (
    input  logic        clk,
    input  logic        rst,
    freq_meter_if.slave bus
);
    typedef enum logic {IDLE, MEAS} gate_state_t;
    typedef enum logic {P_IDLE, P_ARMED} per_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [PER_W-1:0] GATE_LAST = PER_W'(GATE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_MAX   = PER_W'(GATE_CYCLES);

    gate_state_t      gate_state;
    per_state_t       per_state;
    logic             s1, s2, s3;
    logic [PER_W-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] hi_cnt;
    logic             seen;

    logic [CNT_W-1:0] freq_r;
    logic [PER_W-1:0] period_r;
    logic [PER_W-1:0] high_r;
    logic             valid_r;
    logic             ovf_r;
    logic             nosig_r;

    logic rise;
    logic fall;

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    // Both FSMs share one block because each may set or clear no_signal in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_state <= IDLE;
            per_state  <= P_IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            seen       <= 1'b0;
            freq_r     <= '0;
            period_r   <= '0;
            high_r     <= '0;
            valid_r    <= 1'b0;
            ovf_r      <= 1'b0;
            nosig_r    <= 1'b0;
        end else begin
            s1      <= bus.sig_in;
            s2      <= s1;
            s3      <= s2;
            valid_r <= 1'b0;

            case (gate_state)
                IDLE: begin
                    if (bus.en) gate_state <= MEAS;
                end
                MEAS: begin
                    if (!bus.en) begin
                        gate_state <= IDLE;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        ovf        <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        // A rise on the closing cycle still belongs to this window.
                        freq_r   <= (rise && edge_cnt != CNT_MAX) ? edge_cnt + CNT_W'(1) : edge_cnt;
                        ovf_r    <= ovf | (rise & (edge_cnt == CNT_MAX));
                        valid_r  <= 1'b1;
                        if (edge_cnt == '0 && !rise) nosig_r <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + PER_W'(1);
                        if (rise) begin
                            if (edge_cnt == CNT_MAX) ovf <= 1'b1;
                            else                     edge_cnt <= edge_cnt + CNT_W'(1);
                        end
                    end
                end
                default: gate_state <= IDLE;
            endcase

            if (!bus.en) begin
                per_state <= P_IDLE;
                per_cnt   <= '0;
                hi_cnt    <= '0;
                seen      <= 1'b0;
            end else begin
                case (per_state)
                    P_IDLE: begin
                        if (rise) begin
                            per_state <= P_ARMED;
                            per_cnt   <= PER_W'(1);
                            hi_cnt    <= PER_W'(1);
                            seen      <= 1'b1;
                            nosig_r   <= 1'b0;
                        end
                    end
                    P_ARMED: begin
                        if (rise) begin
                            period_r <= per_cnt;
                            per_cnt  <= PER_W'(1);
                            hi_cnt   <= PER_W'(1);
                            nosig_r  <= 1'b0;
                        end else if (per_cnt == PER_MAX) begin
                            period_r  <= '0;
                            nosig_r   <= 1'b1;
                            per_state <= P_IDLE;
                        end else begin
                            per_cnt <= per_cnt + PER_W'(1);
                        end
                        if (!rise && s2 && hi_cnt != PER_MAX) hi_cnt <= hi_cnt + PER_W'(1);
                    end
                    default: per_state <= P_IDLE;
                endcase
                if (fall && seen) high_r <= hi_cnt;
            end
        end
    end

    assign bus.freq_cnt  = freq_r;
    assign bus.period    = period_r;
    assign bus.high_time = high_r;
    assign bus.valid     = valid_r;
    assign bus.overflow  = ovf_r;
    assign bus.no_signal = nosig_r;
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Measures a slow external square wave in the system clock domain. Typical sources are the divided output of the team's clock divider or an off-board test signal.
- Reports three results:
  - rising-edge count over a fixed gate window (frequency);
  - clock cycles between consecutive rising edges (period);
  - clock cycles the signal stays high (high time).
- Results feed the seven-segment and LED display logic.
- This block is the consumer/reader of divided-clock signals; the divider is the producer.

Parameters:
- GATE_CYCLES, 50_000_000, gate window length in clk cycles (1 s at 50 MHz); must be >= 4.
- CNT_W, 26, width of freq_cnt.
- PER_W, 26, width of period and high_time; must be able to hold GATE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  measurement enable; low = idle
- sig_in  input  1  signal under test, asynchronous to clk
- freq_cnt  output  CNT_W  rising edges counted in the last completed window
- period  output  PER_W  clk cycles between the last two rising edges; 0 = none
- high_time  output  PER_W  clk cycles of the last complete high phase
- valid  output  1  one-cycle pulse when freq_cnt/overflow update
- overflow  output  1  last window's edge count saturated
- no_signal  output  1  no rising edge seen for GATE_CYCLES cycles

Behaviour:
- Reset (rst=1 at a clk edge):
  - clears all outputs, counters, synchronizer flops and FSMs to 0/IDLE;
  - a reset mid-window discards the partial window.
- Input conditioning:
  - 3-flop chain s1 -> s2 -> s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge detection latency: 2 clk cycles after sig_in changes.
- Gate FSM:
  - IDLE -> MEAS when en=1; MEAS -> IDLE when en=0.
  - In MEAS, gate_cnt counts 0..GATE_CYCLES-1. edge_cnt increments on rise and saturates at 2^CNT_W-1; a saturating attempt sets an internal ovf flag.
  - On the cycle gate_cnt == GATE_CYCLES-1:
    - freq_cnt <= edge_cnt + rise (saturating); a rise on the final cycle counts in the closing window;
    - overflow <= ovf, including saturation caused by that final rise;
    - valid <= 1 for exactly one cycle;
    - gate_cnt, edge_cnt and ovf clear; the next window starts the following cycle with no gap.
  - Leaving MEAS (en=0): gate_cnt, edge_cnt and ovf clear; no valid pulse; outputs hold their last values.
- Period FSM:
  - P_IDLE -> P_ARMED on the first rise while en=1, with per_cnt <= 1.
  - In P_ARMED, per_cnt increments every cycle and saturates at GATE_CYCLES.
  - On rise: period <= per_cnt, then per_cnt <= 1, and no_signal clears.
  - Timeout: when per_cnt reaches GATE_CYCLES with no rise, period <= 0, no_signal <= 1, state -> P_IDLE.
  - Also in MEAS: a full window with edge_cnt == 0 and no rise on the final cycle sets no_signal=1. This catches a signal that never arms.
  - en=0 forces P_IDLE and clears per_cnt; period and no_signal hold.
- High time:
  - hi_cnt starts at 1 on rise and increments while s2=1 in P_ARMED; saturates at GATE_CYCLES.
  - On fall with a prior rise seen: high_time <= hi_cnt.
  - A fall before any rise is ignored.
- Simultaneous events:
  - Window end together with rise: the edge goes into the closing window; period updates in the same cycle.
  - rise/fall on the cycle en drops: ignored.
- All arithmetic is unsigned. Counters never wrap; they saturate as stated.

Test Plan:
- Nominal: GATE_CYCLES=100000; sig_in toggles every 12500 clk (period 25000), started 10 cycles after en rises.
  - Every window after the first -> freq_cnt=4, overflow=0, valid exactly one cycle every 100000 cycles.
  - After the second rise -> period=25000, high_time=12500.
- No signal: sig_in held 0, en=1, GATE_CYCLES=1000.
  - At cycle 1000 -> valid pulse, freq_cnt=0, no_signal=1, period=0.
  - Then toggling sig_in with period 10: no_signal clears on the next rise; after the second rise -> period=10.
- Overflow: CNT_W=4, GATE_CYCLES=64, sig_in toggles every clk (rise every 2 cycles).
  - -> freq_cnt=15, overflow=1.
  - Following window with sig_in=0 -> freq_cnt=0, overflow=0.
- Final-cycle edge: align one rise so it is detected exactly on gate_cnt == GATE_CYCLES-1.
  - -> counted in the closing window; the next window starts at 0.
- Abort and reset:
  - Drop en at mid-window -> no valid pulse, outputs unchanged.
  - Re-raise en -> first valid arrives exactly GATE_CYCLES cycles after the cycle MEAS is entered.
  - Assert rst mid-window -> every output reads 0 on the next cycle.
